// File: rtl/dpram_fifo_pkg.sv
// Shared defaults and types for the dual-port-RAM FIFO controller.
// Build option: DPFIFO_LEVEL_EN adds the registered level / almost_full outputs.
package dpram_fifo_pkg;

  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 9;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [ADDR_W_DEF:0]   cnt_t;

  // True when one more RAM read may be launched without overrunning the
  // 2-entry output buffer: words already buffered plus the one in flight,
  // minus the one leaving this cycle, must stay below 2.
  function automatic logic issue_room(input logic [1:0] ob_cnt,
                                      input logic       inflight,
                                      input logic       pop);
    logic [2:0] pend;
    pend = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
    return (pend < 3'd2);
  endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_out_buf.sv
// 2-entry output buffer that holds words prefetched from the RAM read port.
// Entry e0 is always the head; e1 is the second-oldest word.
module dpfifo_out_buf
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        ob_cnt
);

  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;
  logic              pop;

  assign rd_valid = (ob_cnt != 2'd0);
  assign rd_data  = e0;
  assign pop      = rd_valid && rd_ready;

  // Shift/append the two entries; capture never arrives when both are full
  // without a simultaneous pop because the issuer reserves room in advance.
  always_ff @(posedge clk) begin
    if (clr) begin
      ob_cnt <= 2'd0;
      e0     <= '0;
      e1     <= '0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) e0 <= cap_data;
          else                e1 <= cap_data;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          e0     <= e1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            e0 <= cap_data;
          end else begin
            e0 <= e1;
            e1 <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller wrapped around an external dual_port_ram.
// Port A is the write side, port B the read side; read data is prefetched
// into a 2-entry output buffer so the consumer sees 1 word/cycle.
// Build option: DPFIFO_LEVEL_EN adds registered level and almost_full ports.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid must not wait for ready, and ready never depends on the
// same side's valid (wr_ready and rd_valid come from registered state only).
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef DPFIFO_LEVEL_EN
  ,
  parameter int AF_THRESH = 6
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_ce,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_adr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_adr_b,
  input  logic [DATA_W-1:0] ram_dout_b
`ifdef DPFIFO_LEVEL_EN
  ,
  output logic [ADDR_W+1:0] level,
  output logic              almost_full
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   ram_cnt;
  logic [ADDR_W:0]   ram_cnt_next;
  logic              inflight;
  logic [1:0]        ob_cnt;
  logic              clr;
  logic              push;
  logic              pop;
  logic              issue;

  assign clr = rst | flush;

  // Space is judged on RAM occupancy only; buffered words live outside it.
  assign wr_ready = !rst && (ram_cnt != FULL_CNT);
  // A push offered during flush is dropped, so it must not touch the RAM.
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = rd_valid && rd_ready;
  assign issue    = !clr && (ram_cnt != '0) && issue_room(ob_cnt, inflight, pop);

  // RAM port drive: write side is combinational on the push, read address
  // simply follows rptr every cycle.
  assign ram_ce    = 1'b1;
  assign ram_we_a  = push;
  assign ram_adr_a = wptr;
  assign ram_din_a = wr_data;
  assign ram_we_b  = 1'b0;
  assign ram_adr_b = rptr;

  // Next RAM occupancy: a push and an issue in the same cycle cancel out.
  always_comb begin
    ram_cnt_next = ram_cnt;
    case ({push, issue})
      2'b10:   ram_cnt_next = ram_cnt + (ADDR_W+1)'(1);
      2'b01:   ram_cnt_next = ram_cnt - (ADDR_W+1)'(1);
      default: ram_cnt_next = ram_cnt;
    endcase
  end

  // Pointers, occupancy and the one-cycle read-in-flight marker.
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + ADDR_W'(1);
      if (issue) rptr <= rptr + ADDR_W'(1);
      ram_cnt  <= ram_cnt_next;
      inflight <= issue;
    end
  end

  // The word read one cycle earlier is captured while inflight is high;
  // clearing inflight on rst/flush discards a pending read.
  dpfifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk      (clk),
    .clr      (clr),
    .capture  (inflight),
    .cap_data (ram_dout_b),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .ob_cnt   (ob_cnt)
  );

`ifdef DPFIFO_LEVEL_EN
  logic [ADDR_W+1:0] ob_next;
  logic [ADDR_W+1:0] level_next;

  // Level is built from next-state values so the register matches the
  // words currently held (RAM + in flight + buffered).
  always_comb begin
    ob_next    = (ADDR_W+2)'(ob_cnt) + (ADDR_W+2)'(inflight) - (ADDR_W+2)'(pop);
    level_next = '0;
    if (!clr) begin
      level_next = (ADDR_W+2)'(ram_cnt_next) + (ADDR_W+2)'(issue) + ob_next;
    end
  end

  // Registered level and threshold flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      almost_full <= (level_next >= (ADDR_W+2)'(AF_THRESH));
    end
  end
`endif

endmodule
